// File: rtl/mul4_pkg.sv
// Shared constants for the 4x4 shift-and-add sequencer: ALU opcodes,
// FSM encoding, microcode length and calculator register indices.
package mul4_pkg;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_SLL = 4'b0111;
  localparam logic [3:0] ALU_SRA = 4'b1001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_READ = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic [4:0] LAST_STEP = 5'd23;

  localparam logic [2:0] R0 = 3'd0;
  localparam logic [2:0] R1 = 3'd1;
  localparam logic [2:0] R2 = 3'd2;
  localparam logic [2:0] R3 = 3'd3;
  localparam logic [2:0] R4 = 3'd4;
  localparam logic [2:0] R5 = 3'd5;
  localparam logic [2:0] R6 = 3'd6;
  localparam logic [2:0] R7 = 3'd7;

endpackage

// File: rtl/mul4_ucode_rom.sv
// Fixed microcode: maps (step, a, b) to one calculator write micro-op.
// R3..R6 hold per-bit masks of b, then the masked/shifted partial products.
module mul4_ucode_rom
  import mul4_pkg::*;
#(
  parameter int DW = 8,
  parameter int NB = 4
) (
  input  logic [4:0]    step_i,
  input  logic [NB-1:0] a_i,
  input  logic [NB-1:0] b_i,
  output logic          wen_o,
  output logic [2:0]    rw_o,
  output logic [2:0]    rx_o,
  output logic [2:0]    ry_o,
  output logic          sel_o,
  output logic [3:0]    ctrl_o,
  output logic [DW-1:0] data_o,
  output logic          is_acc_o
);

  localparam logic [DW-1:0] ONE = {{(DW-1){1'b0}}, 1'b1};

  logic [2:0] bit_reg;
  logic [2:0] pp_reg;
  logic [2:0] shamt;

  assign bit_reg = (step_i < 5'd7)  ? R4 : (step_i < 5'd10) ? R5 : R6;
  assign pp_reg  = (step_i < 5'd18) ? R4 : (step_i < 5'd21) ? R5 : R6;
  // R4/R5/R6 carry bits 1/2/3 of b, so the shift amount is index minus 3
  assign shamt   = pp_reg - 3'd3;

  always_comb begin
    wen_o    = 1'b1;
    rw_o     = R0;
    rx_o     = R0;
    ry_o     = R0;
    sel_o    = 1'b0;
    ctrl_o   = ALU_ADD;
    data_o   = '0;
    is_acc_o = 1'b0;
    case (step_i)
      5'd0: begin rw_o = R1; data_o = {{(DW-NB){1'b0}}, a_i}; end
      5'd1: begin rw_o = R2; data_o = {{(DW-NB){1'b0}}, b_i}; end
      5'd2: begin rw_o = R3; ry_o = R2; ctrl_o = ALU_AND; data_o = ONE; end
      5'd3: begin rw_o = R3; sel_o = 1'b1; ry_o = R3; ctrl_o = ALU_SUB; end
      5'd4, 5'd7, 5'd10: begin
        rw_o = R2; sel_o = 1'b1; ry_o = R2; ctrl_o = ALU_SRA;
      end
      5'd5, 5'd8, 5'd11: begin
        rw_o = bit_reg; ry_o = R2; ctrl_o = ALU_AND; data_o = ONE;
      end
      5'd6, 5'd9, 5'd12: begin
        rw_o = bit_reg; sel_o = 1'b1; ry_o = bit_reg; ctrl_o = ALU_SUB;
      end
      5'd13: begin rw_o = R3; sel_o = 1'b1; rx_o = R1; ry_o = R3; ctrl_o = ALU_AND; end
      5'd14: begin rw_o = R7; sel_o = 1'b1; ry_o = R3; is_acc_o = 1'b1; end
      5'd15, 5'd18, 5'd21: begin
        rw_o = pp_reg; sel_o = 1'b1; rx_o = R1; ry_o = pp_reg; ctrl_o = ALU_AND;
      end
      5'd16, 5'd19, 5'd22: begin
        rw_o = pp_reg; ry_o = pp_reg; ctrl_o = ALU_SLL;
        data_o = {{(DW-3){1'b0}}, shamt};
      end
      5'd17, 5'd20, 5'd23: begin
        rw_o = R7; sel_o = 1'b1; rx_o = R7; ry_o = pp_reg; is_acc_o = 1'b1;
      end
      default: wen_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/mul4_sequencer.sv
// Drives simple_calculator through a 24-step shift-and-add microprogram.
// state | meaning: IDLE wait start, EXEC issue step, READ capture R7, DONE pulse done
module mul4_sequencer
  import mul4_pkg::*;
#(
  parameter int DW = 8,
  parameter int NB = 4
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          start,
  input  logic [NB-1:0] a,
  input  logic [NB-1:0] b,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] product,
  output logic          ovf,
  output logic          WEN,
  output logic [2:0]    RW,
  output logic [2:0]    RX,
  output logic [2:0]    RY,
  output logic [DW-1:0] DataIn,
  output logic          Sel,
  output logic [3:0]    Ctrl,
  input  logic [DW-1:0] busY,
  input  logic          Carry
);

  state_e        state_q, state_d;
  logic [4:0]    step_q, step_d;
  logic [NB-1:0] a_q, a_d, b_q, b_d;
  logic [DW-1:0] product_q, product_d;
  logic          ovf_q, ovf_d;

  logic          rom_wen, rom_sel, rom_acc;
  logic [2:0]    rom_rw, rom_rx, rom_ry;
  logic [3:0]    rom_ctrl;
  logic [DW-1:0] rom_data;

  mul4_ucode_rom #(.DW(DW), .NB(NB)) u_rom (
    .step_i   (step_q),
    .a_i      (a_q),
    .b_i      (b_q),
    .wen_o    (rom_wen),
    .rw_o     (rom_rw),
    .rx_o     (rom_rx),
    .ry_o     (rom_ry),
    .sel_o    (rom_sel),
    .ctrl_o   (rom_ctrl),
    .data_o   (rom_data),
    .is_acc_o (rom_acc)
  );

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q   <= ST_IDLE;
      step_q    <= '0;
      a_q       <= '0;
      b_q       <= '0;
      product_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      a_q       <= a_d;
      b_q       <= b_d;
      product_q <= product_d;
      ovf_q     <= ovf_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    a_d       = a_q;
    b_d       = b_q;
    product_d = product_q;
    ovf_d     = ovf_q;
    busy      = 1'b0;
    done      = 1'b0;
    WEN       = 1'b0;
    RW        = R0;
    RX        = R0;
    RY        = R0;
    Sel       = 1'b0;
    Ctrl      = ALU_ADD;
    DataIn    = '0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          ovf_d   = 1'b0;
          step_d  = '0;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        busy   = 1'b1;
        WEN    = rom_wen;
        RW     = rom_rw;
        RX     = rom_rx;
        RY     = rom_ry;
        Sel    = rom_sel;
        Ctrl   = rom_ctrl;
        DataIn = rom_data;
        // only accumulate adds into R7 can overflow the product
        ovf_d  = ovf_q | (rom_acc & Carry);
        if (step_q == LAST_STEP) state_d = ST_READ;
        else                     step_d  = step_q + 5'd1;
      end
      ST_READ: begin
        busy      = 1'b1;
        RY        = R7;
        Sel       = 1'b1;
        Ctrl      = ALU_OR;
        product_d = busY;
        state_d   = ST_DONE;
      end
      ST_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign product = product_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_mul4_sequencer.sv
// Directed bench for mul4_sequencer with a behavioural simple_calculator
// attached; the carry line can be forced to exercise the overflow flag.
module tb_mul4_sequencer;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_SLL = 4'b0111;
  localparam logic [3:0] OP_SRA = 4'b1001;

  logic       Clk = 1'b0;
  logic       Rst, start;
  logic [3:0] a, b;
  logic       busy, done, ovf, WEN, Sel, Carry;
  logic [7:0] product, DataIn, busY;
  logic [2:0] RW, RX, RY;
  logic [3:0] Ctrl;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 Clk = ~Clk;

  mul4_sequencer #(.DW(8), .NB(4)) dut (
    .Clk(Clk), .Rst(Rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .product(product), .ovf(ovf),
    .WEN(WEN), .RW(RW), .RX(RX), .RY(RY), .DataIn(DataIn),
    .Sel(Sel), .Ctrl(Ctrl), .busY(busY), .Carry(Carry)
  );

  // behavioural calculator; R0 reads zero, other registers start dirty
  logic [7:0] rf [8];
  logic       tb_init;
  logic [1:0] cmode;
  logic [7:0] x_op, y_op, alu_r;
  logic       alu_c, force_c;

  always_comb begin
    x_op  = Sel ? ((RX == 3'd0) ? 8'd0 : rf[RX]) : DataIn;
    y_op  = (RY == 3'd0) ? 8'd0 : rf[RY];
    alu_r = 8'd0;
    alu_c = 1'b0;
    case (Ctrl)
      OP_ADD: {alu_c, alu_r} = {1'b0, x_op} + {1'b0, y_op};
      OP_SUB: {alu_c, alu_r} = {1'b0, x_op} - {1'b0, y_op};
      OP_AND: alu_r = x_op & y_op;
      OP_OR:  alu_r = x_op | y_op;
      OP_SLL: alu_r = y_op << x_op[2:0];
      OP_SRA: alu_r = $signed(y_op) >>> 1;
      default: alu_r = 8'd0;
    endcase
  end

  assign force_c = (cmode == 2'd1 && WEN && RW == 3'd7 && RY == 3'd4) ||
                   (cmode == 2'd2 && WEN && RW != 3'd7);
  assign busY  = alu_r;
  assign Carry = alu_c | force_c;

  always @(posedge Clk) begin
    if (tb_init) begin
      for (int i = 0; i < 8; i++) rf[i] <= 8'hA5;
    end else if (WEN && RW != 3'd0) begin
      rf[RW] <= alu_r;
    end
  end

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  function automatic logic [22:0] pk(input logic [2:0] rw, input logic [2:0] rx,
                                     input logic [2:0] ry, input logic sel,
                                     input logic [3:0] op, input logic [7:0] d);
    return {1'b1, rw, rx, ry, sel, op, d};
  endfunction

  function automatic logic [22:0] exp_uop(input int s, input logic [3:0] aa, input logic [3:0] bb);
    case (s)
      0:  return pk(3'd1, 3'd0, 3'd0, 1'b0, OP_ADD, {4'd0, aa});
      1:  return pk(3'd2, 3'd0, 3'd0, 1'b0, OP_ADD, {4'd0, bb});
      2:  return pk(3'd3, 3'd0, 3'd2, 1'b0, OP_AND, 8'd1);
      3:  return pk(3'd3, 3'd0, 3'd3, 1'b1, OP_SUB, 8'd0);
      4:  return pk(3'd2, 3'd0, 3'd2, 1'b1, OP_SRA, 8'd0);
      5:  return pk(3'd4, 3'd0, 3'd2, 1'b0, OP_AND, 8'd1);
      6:  return pk(3'd4, 3'd0, 3'd4, 1'b1, OP_SUB, 8'd0);
      7:  return pk(3'd2, 3'd0, 3'd2, 1'b1, OP_SRA, 8'd0);
      8:  return pk(3'd5, 3'd0, 3'd2, 1'b0, OP_AND, 8'd1);
      9:  return pk(3'd5, 3'd0, 3'd5, 1'b1, OP_SUB, 8'd0);
      10: return pk(3'd2, 3'd0, 3'd2, 1'b1, OP_SRA, 8'd0);
      11: return pk(3'd6, 3'd0, 3'd2, 1'b0, OP_AND, 8'd1);
      12: return pk(3'd6, 3'd0, 3'd6, 1'b1, OP_SUB, 8'd0);
      13: return pk(3'd3, 3'd1, 3'd3, 1'b1, OP_AND, 8'd0);
      14: return pk(3'd7, 3'd0, 3'd3, 1'b1, OP_ADD, 8'd0);
      15: return pk(3'd4, 3'd1, 3'd4, 1'b1, OP_AND, 8'd0);
      16: return pk(3'd4, 3'd0, 3'd4, 1'b0, OP_SLL, 8'd1);
      17: return pk(3'd7, 3'd7, 3'd4, 1'b1, OP_ADD, 8'd0);
      18: return pk(3'd5, 3'd1, 3'd5, 1'b1, OP_AND, 8'd0);
      19: return pk(3'd5, 3'd0, 3'd5, 1'b0, OP_SLL, 8'd2);
      20: return pk(3'd7, 3'd7, 3'd5, 1'b1, OP_ADD, 8'd0);
      21: return pk(3'd6, 3'd1, 3'd6, 1'b1, OP_AND, 8'd0);
      22: return pk(3'd6, 3'd0, 3'd6, 1'b0, OP_SLL, 8'd3);
      23: return pk(3'd7, 3'd7, 3'd6, 1'b1, OP_ADD, 8'd0);
      default: return 23'd0;
    endcase
  endfunction

  // runs one product from an IDLE cycle; returns cycles to done, leaves bench in IDLE
  task automatic do_run(input logic [3:0] aa, input logic [3:0] bb,
                        output int lat, output logic [7:0] prod, output logic ov);
    a = aa; b = bb; start = 1'b1;
    tick;
    start = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 40) begin
      tick;
      lat++;
    end
    prod = product;
    ov   = ovf;
    tick;
  endtask

  task automatic test_reset;
    Rst = 1'b1; tb_init = 1'b1; cmode = 2'd0;
    start = 1'b1; a = 4'hF; b = 4'hF;
    tick; tick;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++; if (product !== 8'd0) begin n_bad++; $display("FAIL reset_product: got %0d want 0", product); end
    n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL reset_ovf: got %b want 0", ovf); end
    n_cmp++; if ({WEN, RW, RX, RY, Sel, Ctrl, DataIn} !== 23'd0) begin
      n_bad++; $display("FAIL reset_ctrl: got %h want 0", {WEN, RW, RX, RY, Sel, Ctrl, DataIn});
    end
    Rst = 1'b0; tb_init = 1'b0; start = 1'b0;
    tick;
    n_cmp++; if (busy !== 1'b0 || WEN !== 1'b0) begin
      n_bad++; $display("FAIL idle_after_reset: busy %b WEN %b want 0 0", busy, WEN);
    end
  endtask

  task automatic test_trace;
    logic [22:0] e, m, obs;
    a = 4'd13; b = 4'd12; start = 1'b1;
    tick;
    start = 1'b0;
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL trace_busy: got %b want 1", busy); end
    for (int s = 0; s < 24; s++) begin
      e = exp_uop(s, 4'd13, 4'd12);
      m = '1;
      if (e[11:8] == OP_SRA) begin m[18:16] = 3'd0; m[12] = 1'b0; m[7:0] = 8'd0; end
      else if (e[12])        m[7:0] = 8'd0;
      else                   m[18:16] = 3'd0;
      obs = {WEN, RW, RX, RY, Sel, Ctrl, DataIn};
      n_cmp++;
      if ((obs & m) !== (e & m)) begin
        n_bad++; $display("FAIL trace_step%0d: bus %h required %h mask %h", s, obs, e, m);
      end
      tick;
    end
    n_cmp++; if ({WEN, RX, RY, Sel, Ctrl} !== {1'b0, 3'd0, 3'd7, 1'b1, OP_OR}) begin
      n_bad++; $display("FAIL trace_read: got %h want %h", {WEN, RX, RY, Sel, Ctrl}, {1'b0, 3'd0, 3'd7, 1'b1, OP_OR});
    end
    tick;
    n_cmp++; if (done !== 1'b1 || busy !== 1'b1) begin
      n_bad++; $display("FAIL trace_done_cycle26: done %b busy %b want 1 1", done, busy);
    end
    n_cmp++; if (product !== 8'd156) begin n_bad++; $display("FAIL trace_product: got %0d want 156", product); end
    n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL trace_ovf: got %b want 0", ovf); end
    tick;
    n_cmp++; if (done !== 1'b0 || busy !== 1'b0 || product !== 8'd156) begin
      n_bad++; $display("FAIL trace_after_done: done %b busy %b product %0d want 0 0 156", done, busy, product);
    end
  endtask

  task automatic test_values;
    logic [3:0] va [3] = '{4'd15, 4'd0, 4'd7};
    logic [3:0] vb [3] = '{4'd15, 4'd9, 4'd0};
    logic [7:0] vp [3] = '{8'd225, 8'd0, 8'd0};
    int lat; logic [7:0] p; logic ov;
    for (int i = 0; i < 3; i++) begin
      do_run(va[i], vb[i], lat, p, ov);
      n_cmp++; if (lat !== 26) begin n_bad++; $display("FAIL values%0d_latency: got %0d want 26", i, lat); end
      n_cmp++; if (p !== vp[i]) begin n_bad++; $display("FAIL values%0d_product: got %0d want %0d", i, p, vp[i]); end
      n_cmp++; if (ov !== 1'b0) begin n_bad++; $display("FAIL values%0d_ovf: got %b want 0", i, ov); end
    end
  endtask

  task automatic test_ignore_start;
    int nd = 0, dcyc = 0;
    logic [7:0] dprod = 8'd0;
    a = 4'd5; b = 4'd3; start = 1'b1;
    for (int c = 1; c <= 35; c++) begin
      tick;
      start = (c == 5 || c == 20);
      if (start) begin a = 4'd1; b = 4'd1; end
      if (done === 1'b1) begin nd++; dcyc = c; dprod = product; end
    end
    start = 1'b0;
    n_cmp++; if (nd !== 1) begin n_bad++; $display("FAIL ignore_done_count: got %0d want 1", nd); end
    n_cmp++; if (dcyc !== 26) begin n_bad++; $display("FAIL ignore_done_cycle: got %0d want 26", dcyc); end
    n_cmp++; if (dprod !== 8'd15) begin n_bad++; $display("FAIL ignore_product: got %0d want 15", dprod); end
  endtask

  task automatic test_reset_mid;
    int lat; logic [7:0] p; logic ov;
    a = 4'd13; b = 4'd12; start = 1'b1;
    tick;
    start = 1'b0;
    for (int c = 2; c <= 10; c++) tick;
    Rst = 1'b1;
    tick;
    n_cmp++; if (busy !== 1'b0 || WEN !== 1'b0 || done !== 1'b0) begin
      n_bad++; $display("FAIL midreset_idle: busy %b WEN %b done %b want 0 0 0", busy, WEN, done);
    end
    n_cmp++; if (product !== 8'd0) begin n_bad++; $display("FAIL midreset_product: got %0d want 0", product); end
    Rst = 1'b0;
    tick;
    do_run(4'd3, 4'd5, lat, p, ov);
    n_cmp++; if (lat !== 26) begin n_bad++; $display("FAIL midreset_rerun_latency: got %0d want 26", lat); end
    n_cmp++; if (p !== 8'd15) begin n_bad++; $display("FAIL midreset_rerun_product: got %0d want 15", p); end
  endtask

  task automatic test_back_to_back;
    int nd = 0, cyc = 0;
    int dc [3] = '{0, 0, 0};
    logic [7:0] pr [3] = '{8'd0, 8'd0, 8'd0};
    int edc [3] = '{26, 53, 80};
    logic [7:0] epr [3] = '{8'd6, 8'd16, 8'd81};
    a = 4'd2; b = 4'd3; start = 1'b1;
    while (nd < 3 && cyc < 100) begin
      tick;
      cyc++;
      if (done === 1'b1) begin
        dc[nd] = cyc; pr[nd] = product; nd++;
        if (nd == 1) begin a = 4'd4; b = 4'd4; end
        else if (nd == 2) begin a = 4'd9; b = 4'd9; end
        else start = 1'b0;
      end
    end
    start = 1'b0;
    tick;
    n_cmp++; if (nd !== 3) begin n_bad++; $display("FAIL b2b_done_count: got %0d want 3", nd); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (dc[i] !== edc[i]) begin n_bad++; $display("FAIL b2b_cycle%0d: got %0d want %0d", i, dc[i], edc[i]); end
      n_cmp++; if (pr[i] !== epr[i]) begin n_bad++; $display("FAIL b2b_product%0d: got %0d want %0d", i, pr[i], epr[i]); end
    end
  endtask

  task automatic test_ovf;
    int lat; logic [7:0] p; logic ov;
    cmode = 2'd1;
    do_run(4'd13, 4'd12, lat, p, ov);
    n_cmp++; if (ov !== 1'b1) begin n_bad++; $display("FAIL ovf_step17: got %b want 1", ov); end
    n_cmp++; if (ovf !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky_idle: got %b want 1", ovf); end
    cmode = 2'd2;
    do_run(4'd13, 4'd12, lat, p, ov);
    n_cmp++; if (ov !== 1'b0) begin n_bad++; $display("FAIL ovf_clear_nonacc: got %b want 0", ov); end
    n_cmp++; if (p !== 8'd156) begin n_bad++; $display("FAIL ovf_run_product: got %0d want 156", p); end
    cmode = 2'd0;
  endtask

  initial begin
    test_reset;
    test_trace;
    test_values;
    test_ignore_start;
    test_reset_mid;
    test_back_to_back;
    test_ovf;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1);
  end

endmodule
